// File: rtl/spi_peripheral_if.sv
// SPI pins plus the tx/rx word streams of the SPI responder.
// The slave modport is the peripheral's view. The master modport is the view of the link partner and the host.
interface spi_peripheral_if #(
  parameter int unsigned WIDTH = 8
);
  logic             SCK;
  logic             CS;
  logic             MOSI;
  logic             MISO;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;

  modport slave (
    input  SCK, CS, MOSI, tx_data, tx_valid,
    output MISO, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport master (
    output SCK, CS, MOSI, tx_data, tx_valid,
    input  MISO, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_peripheral.sv
// Mode-0, MSB-first SPI responder oversampled on clk.
// It has a single-word tx buffer and no rx backpressure.
module spi_peripheral #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  spi_peripheral_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q;

  state_e           state_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [WIDTH-1:0] rx_shift_q, rx_data_q, tx_buf_q, tx_shift_q;
  logic             rx_valid_q, tx_full_q, underrun_q, miso_q, miso_oe_q;

  logic             last_bit, boundary, tx_load;
  logic [WIDTH-1:0] next_word;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  // A CS low that is held through reset must not look like a fresh frame start.
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;

  assign last_bit  = (bit_cnt_q == CntW'(WIDTH - 1));
  assign boundary  = ((state_q == StIdle) & cs_fall) |
                     ((state_q == StActive) & ~cs_rise & sck_fall & (bit_cnt_q == '0));
  assign tx_load   = bus.tx_valid & ~tx_full_q;
  assign next_word = tx_full_q ? tx_buf_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= '0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      if (flush_q[SYNC_STAGES] && cs_s) begin
        armed_q <= 1'b1;
      end

      rx_valid_q <= 1'b0;

      // A load never coincides with a full buffer, so the consume always sees the old state.
      if (tx_load) begin
        tx_buf_q  <= bus.tx_data;
        tx_full_q <= 1'b1;
      end else if (boundary) begin
        tx_full_q <= 1'b0;
      end

      if (boundary) begin
        tx_shift_q <= next_word;
        miso_q     <= next_word[WIDTH-1];
        if (!tx_full_q) begin
          underrun_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StActive;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b1;
          end
        end
        StActive: begin
          if (cs_rise) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_shift_q <= {rx_shift_q[WIDTH-2:0], mosi_s};
              if (last_bit) begin
                rx_data_q  <= {rx_shift_q[WIDTH-2:0], mosi_s};
                rx_valid_q <= 1'b1;
                bit_cnt_q  <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
            if (sck_fall && (bit_cnt_q != '0)) begin
              tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
              miso_q     <= tx_shift_q[WIDTH-2];
            end
          end
        end
      endcase
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ready    = ~tx_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral. A word-level model predicts each received word, each MISO word and the underrun flag.
// A monitor checks these predictions on every rx_valid strobe.
module tb_spi_peripheral;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SYNC  = 2;

  typedef struct packed {
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] tx;
    logic             unr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_peripheral_if #(.WIDTH(WIDTH)) bus ();

  spi_peripheral #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] tx_model_q[$];
  logic             model_unr;
  logic [WIDTH-1:0] model_rx;
  logic [WIDTH-1:0] cur_tx;
  logic [WIDTH-1:0] miso_cap, last_miso;
  logic [WIDTH-1:0] frame_words[$];
  int               frame_mid[$];
  logic             prev_rxv = 1'b0;
  exp_t             mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // At a word boundary the responder sends the buffered word, or zeros if nothing is buffered.
  task automatic model_boundary();
    if (tx_model_q.size() > 0) begin
      cur_tx = tx_model_q.pop_front();
    end else begin
      cur_tx    = '0;
      model_unr = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [WIDTH-1:0] d);
    int n = 0;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) begin
      check("tx_load_timeout", bus.tx_ready, 1);
    end else begin
      @(posedge clk);
      tx_model_q.push_back(d);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // One mode-0 bit: present MOSI, raise SCK (master samples MISO), then lower SCK.
  task automatic sck_bit(input logic b, input int half, input logic last, input logic [WIDTH-1:0] word);
    bus.MOSI = b;
    repeat (half) @(negedge clk);
    bus.SCK  = 1'b1;
    miso_cap = {miso_cap[WIDTH-2:0], bus.MISO};
    if (last) begin
      last_miso = miso_cap;
      model_rx  = word;
      sb_q.push_back('{rx: word, tx: cur_tx, unr: model_unr});
    end
    repeat (half) @(negedge clk);
    bus.SCK = 1'b0;
  endtask

  task automatic run_frame(input int half, input int partial);
    logic [WIDTH-1:0] word;
    @(negedge clk);
    bus.CS = 1'b0;
    model_boundary();
    repeat (SYNC + 1) @(negedge clk);
    check("start_miso_oe", bus.miso_oe, 1);
    check("start_miso_msb", bus.MISO, cur_tx[WIDTH-1]);
    check("start_tx_ready", bus.tx_ready, tx_model_q.size() == 0);
    if (partial > 0) begin
      word = frame_words[0];
      for (int i = 0; i < partial; i++) sck_bit(word[WIDTH-1-i], half, 1'b0, '0);
    end else begin
      for (int w = 0; w < frame_words.size(); w++) begin
        word = frame_words[w];
        for (int b = WIDTH - 1; b >= 0; b--) begin
          sck_bit(word[b], half, b == 0, word);
          if (b == 4 && frame_mid[w] >= 0 && tx_model_q.size() == 0) load_tx(WIDTH'(frame_mid[w]));
        end
        model_boundary();
      end
    end
    repeat (half) @(negedge clk);
    bus.CS = 1'b1;
    frame_words.delete();
    frame_mid.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"}, bus.MISO, 0);
    check({tag, "_miso_oe"}, bus.miso_oe, 0);
    check({tag, "_rx_data"}, bus.rx_data, 0);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_tx_ready"}, bus.tx_ready, 1);
    check({tag, "_tx_underrun"}, bus.tx_underrun, 0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  // Monitor: every rx_valid strobe must match the oldest predicted word.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) begin
        check("rx_valid_one_cycle", prev_rxv, 0);
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rx_valid: got strobe with rx_data 0x%0h, required none", bus.rx_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("rx_data", bus.rx_data, mon_e.rx);
          check("miso_word", last_miso, mon_e.tx);
          check("underrun_at_word", bus.tx_underrun, mon_e.unr);
        end
      end
      prev_rxv = bus.rx_valid;
    end
  end

  initial begin
    #1000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, half;
    bus.SCK = 1'b0; bus.CS = 1'b1; bus.MOSI = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    model_unr = 1'b0; model_rx = '0; cur_tx = '0; miso_cap = '0; last_miso = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");
    idle(10);

    // 1: single word, buffer preloaded
    load_tx(8'hA5);
    frame_words.push_back(8'h3C); frame_mid.push_back(-1);
    run_frame(4, 0);
    idle(10);
    check("t1_tx_ready", bus.tx_ready, 1);
    check("t1_underrun", bus.tx_underrun, model_unr);

    // 2: two words in one frame, second tx word loaded mid-word
    load_tx(8'h11);
    frame_words.push_back(8'hF0); frame_mid.push_back(8'h22);
    frame_words.push_back(8'h0F); frame_mid.push_back(-1);
    run_frame(4, 0);
    idle(10);

    // 3: empty buffer sends zeros and sets the sticky underrun
    frame_words.push_back(8'h81); frame_mid.push_back(-1);
    run_frame(4, 0);
    idle(10);
    check("t3_underrun", bus.tx_underrun, 1);
    check("t3_rx_data", bus.rx_data, 8'h81);

    // 4: aborted frame after 5 bits, then a full frame
    frame_words.push_back(8'hFF); frame_mid.push_back(-1);
    run_frame(4, 5);
    repeat (SYNC + 1) @(negedge clk);
    check("t4_abort_miso", bus.MISO, 0);
    check("t4_abort_miso_oe", bus.miso_oe, 0);
    check("t4_abort_rx_kept", bus.rx_data, model_rx);
    idle(10);
    frame_words.push_back(8'h55); frame_mid.push_back(-1);
    run_frame(4, 0);
    idle(10);
    check("t4_rx_data", bus.rx_data, 8'h55);

    // 5: reset mid-frame with CS held low
    load_tx(8'h44);
    @(negedge clk);
    bus.CS = 1'b0;
    model_boundary();
    repeat (SYNC + 1) @(negedge clk);
    for (int i = 0; i < 3; i++) sck_bit(1'b1, 4, 1'b0, '0);
    load_tx(8'h5D);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_model_q.delete();
    model_unr = 1'b0;
    model_rx  = '0;
    check_reset("t5_rst");
    for (int i = 0; i < WIDTH; i++) sck_bit(1'b1, 4, 1'b0, '0);
    idle(4);
    check("t5_idle_miso_oe", bus.miso_oe, 0);
    check("t5_idle_rx_data", bus.rx_data, 0);
    bus.CS = 1'b1;
    idle(10);
    frame_words.push_back(8'h9A); frame_mid.push_back(-1);
    run_frame(4, 0);
    idle(10);

    // 6: tx_valid held while the buffer is full
    load_tx(8'h1D);
    frame_words.push_back(8'hC3); frame_mid.push_back(-1);
    frame_words.push_back(8'h3A); frame_mid.push_back(-1);
    frame_words.push_back(8'h6B); frame_mid.push_back(-1);
    fork
      run_frame(4, 0);
      begin
        int n = 0;
        repeat (20) @(negedge clk);
        load_tx(8'hB2);
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_tx_ready_full", bus.tx_ready, 0);
        while (!bus.tx_ready && n < 300) begin
          @(negedge clk);
          n++;
        end
        if (!bus.tx_ready) begin
          check("t6_ready_timeout", bus.tx_ready, 1);
        end else begin
          @(posedge clk);
          tx_model_q.push_back(8'h77);
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    idle(10);

    // Randomised frames
    for (int f = 0; f < 12; f++) begin
      nw   = $urandom_range(1, 3);
      half = $urandom_range(SYNC + 2, SYNC + 4);
      if ($urandom_range(0, 1) == 1 && tx_model_q.size() == 0) load_tx(WIDTH'($urandom));
      for (int w = 0; w < nw; w++) begin
        frame_words.push_back(WIDTH'($urandom));
        frame_mid.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1);
      end
      run_frame(half, 0);
      idle($urandom_range(6, 15));
      check("rand_underrun", bus.tx_underrun, model_unr);
      check("rand_tx_ready", bus.tx_ready, tx_model_q.size() == 0);
    end

    idle(20);
    check("scoreboard_drained", sb_q.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI responder (slave) for the other end of the team's SPI master link. Mode 0, MSB first, WIDTH-bit words.
- Oversamples SCK, CS and MOSI on the local system clock.
- Deserialises MOSI into rx_data with a one-cycle rx_valid strobe.
- Serialises a word loaded through a valid/ready port onto MISO. Multiple back-to-back words are allowed within one CS-low frame.

Parameters:
- WIDTH, 8, word length in bits.
- SYNC_STAGES, 2, flops in each input synchroniser for SCK, CS and MOSI (minimum 2).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SCK  in  1  SPI clock from the master; asynchronous to clk.
- CS  in  1  chip select, active-low; asynchronous.
- MOSI  in  1  serial data from the master; asynchronous.
- MISO  out  1  serial data to the master.
- miso_oe  out  1  MISO output enable; high only while the frame is active.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit buffer can accept a word.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle strobe: rx_data has been updated.
- tx_underrun  out  1  sticky flag: a word boundary arrived while the tx buffer was empty. Cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, MISO=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0. Tx buffer is empty. bit_cnt=0. All synchroniser flops preset to SCK=0, CS=1, MOSI=0.
- Synchronisation: each input passes through SYNC_STAGES flops, giving sck_s, cs_s, mosi_s. A 1-flop history of each drives edge detection: sck_rise, sck_fall, cs_fall, cs_rise.
- Timing requirement: SCK high and low phases are each at least SYNC_STAGES+2 clk periods. Faster SCK is out of spec and behaviour is undefined.
- Tx buffer: a single WIDTH-bit register plus a full flag. tx_ready = !full. tx_valid && tx_ready loads the register and sets full.
- Tx buffer consumption happens at every word boundary (defined below). If full: the word moves into tx_shift and full clears. If empty: tx_shift is loaded with all zeros and tx_underrun is set.
- Load and consume in the same cycle: the consume sees the pre-cycle state. If the buffer was empty, zeros are sent and the newly loaded word is kept for the next boundary.
- State IDLE: MISO=0, miso_oe=0. On cs_fall: go to ACTIVE, bit_cnt=0, word boundary (consume buffer), MISO = tx_shift MSB, miso_oe=1. MISO is valid SYNC_STAGES+1 clks after the CS pin falls.
- ACTIVE, on sck_rise: rx_shift = {rx_shift[WIDTH-2:0], mosi_s}; bit_cnt increments.
- ACTIVE, sck_rise with bit_cnt==WIDTH-1: rx_data = {rx_shift[WIDTH-2:0], mosi_s}; rx_valid=1 for exactly one clk; bit_cnt wraps to 0.
- ACTIVE, on sck_fall: if bit_cnt != 0, tx_shift shifts left and MISO = next bit.
- ACTIVE, sck_fall with bit_cnt==0 (first falling edge after a completed word): word boundary; consume buffer; MISO = new MSB.
- ACTIVE, on cs_rise: go to IDLE; MISO=0, miso_oe=0; bit_cnt=0. A partial rx word is discarded with no rx_valid. Any partially sent tx word is lost, and the buffer contents (if full) are retained.
- cs_rise and sck_rise in the same cycle: cs_rise wins; the rising SCK edge is ignored.
- SCK edges while in IDLE are ignored.
- rx has no backpressure: each completed word overwrites rx_data.
- Latency: rx_valid rises SYNC_STAGES+1 clks after the final SCK rising edge on the pin.
- rst asserted mid-frame: immediate return to reset values. The block stays in IDLE until a fresh cs_fall, even if CS is still low when rst deasserts.

Test Plan:
1. Load tx 0xA5, then master sends 0x3C (8 SCK, half-period 4 clk) -> MISO bits sampled by the master on rising SCK read 0xA5; rx_data=0x3C; one rx_valid pulse; tx_underrun=0; tx_ready=1 after CS falls.
2. Load 0x11 before CS falls and 0x22 during the first word; master sends 0xF0 then 0x0F in one CS-low frame -> MISO reads 0x11 then 0x22; rx_valid pulses twice with rx_data 0xF0 then 0x0F.
3. Empty tx buffer, master sends 0x81 -> MISO reads 0x00; tx_underrun=1 and stays 1; rx_data=0x81.
4. CS rises after 5 SCK cycles of 0xFF -> no rx_valid; rx_data keeps its previous value; MISO=0 and miso_oe=0 within SYNC_STAGES+1 clks. The next full frame with 0x55 gives rx_data=0x55.
5. Assert rst after bit 3 of a frame with CS held low -> all outputs at reset values. SCK pulses produce nothing until CS toggles high then low; the following 0x9A frame is received correctly.
6. tx_valid held with tx_data=0x77 while the buffer is full -> tx_ready=0 and no overwrite. Buffer consumed at the boundary -> tx_ready=1, 0x77 accepted on the next clk, sent in the following word.
